hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine with the architectural HI/LO register pair.
- It sits beside the Executs32 ALU and consumes the same operands (Read_data_1, Read_data_2) plus the decoded mult/multu/div/divu Function_opcode.
- It computes the result iteratively and holds it in HI/LO for mfhi/mflo.
- It also services mthi/mtlo writes, and raises busy so the controller can stall mfhi/mflo and further mul/div issue.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu. Equal to Function_opcode[1:0] of 01_10xx.
- Read_data_1  in  WIDTH  rs operand (multiplicand / dividend).
- Read_data_2  in  WIDTH  rt operand (multiplier / divisor).
- mthi  in  1  write wdata into HI.
- mtlo  in  1  write wdata into LO.
- wdata  in  WIDTH  data for mthi/mtlo (rs value).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- div_zero  out  1  pulses together with done when a div/divu had a zero divisor.
- HI_result  out  WIDTH  HI register.
- LO_result  out  WIDTH  LO register.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0.
  - HI_result=0, LO_result=0.
  - busy=0, done=0, div_zero=0.
  - All internal operand registers cleared.
  - Reset mid-operation aborts the operation; no partial result is ever visible.
- State machine: IDLE -> RUN -> FIX -> IDLE.
  - IDLE, start=1: latch op, |A| and |B| (raw values for multu/divu), and the result signs. Signed quotient/product sign = A[31]^B[31]; remainder sign = A[31]. Then counter=0 and go to RUN.
  - RUN: one iteration per cycle for exactly WIDTH cycles, then FIX.
    - Multiply: shift-add on a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract on a WIDTH-bit remainder / quotient pair.
  - FIX: apply the two's-complement sign correction for mult/div. Write HI/LO (mult: HI=upper half, LO=lower half; div: LO=quotient, HI=remainder). Pulse done, go to IDLE.
- Timing: busy=1 in RUN and FIX. done is high in the cycle after the FIX edge, coinciding with the new HI/LO and busy=0. Latency from the start edge to done is WIDTH+2 = 34 cycles.
- start while busy is ignored; no queuing.
- mthi/mtlo:
  - Take effect on the next edge only when state=IDLE and start=0.
  - Both may assert in the same cycle; both registers are written.
  - While busy, or with start=1 in the same cycle, they are ignored; start has priority.
- Divide by zero:
  - LO=32'hFFFF_FFFF, HI=Read_data_1 as latched (raw dividend), for both div and divu.
  - No sign fixup is applied; div_zero pulses with done.
- Signed overflow: 0x8000_0000 div 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. This falls out naturally from the magnitude algorithm.
- Remainder sign follows the dividend, and the quotient truncates toward zero. Results must match $signed / and % for nonzero divisors.
- Operands are sampled only at start; later changes on Read_data_1/2 have no effect.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - state encodings S_IDLE, S_RUN, S_FIX.
  - Constant DIV0_QUOT = 32'hFFFF_FFFF.
- One natural sub-module, muldiv_iter_core, holding the per-cycle shift-add / shift-subtract datapath. hilo_muldiv_unit owns the FSM, sign handling, and the HI/LO registers.

Test Plan:
- Reset mid-op: reset_n low at cycle 10 of a running op -> HI=LO=0, busy=0; no done pulse after release.
- mult -3 x 7 (A=0xFFFF_FFFD, B=7) -> done at cycle 34 with HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. busy high for cycles 1..33.
- multu 0xFFFF_FFFF x 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- div -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). divu 7/0 -> LO=0xFFFF_FFFF, HI=7, div_zero=1 with done.
- div 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0. A second start at cycle 5 is ignored: exactly one done.
- Idle mthi=mtlo=1, wdata=0x1234_5678 -> both registers read 0x1234_5678. mthi while busy -> HI unchanged until the op result. start+mtlo in the same cycle -> mtlo dropped.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  // Operation select, equal to Function_opcode[1:0] of mult/multu/div/divu.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  // Quotient reported for any divide by zero.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // mult and div treat operands as two's complement.
  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // The upper op bit separates the divide family from the multiply family.
  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative magnitude datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on a shared 2*WIDTH accumulator.
// Multiply: low half starts as the multiplier and ends as the low product;
//           high half accumulates the upper product.
// Divide:   low half starts as the dividend and ends as the quotient;
//           high half is the running remainder.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;

  // One iteration of whichever algorithm is loaded.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = shifted - {1'b0, b_q};
    acc_next = {add_sum, acc_q[WIDTH-1:1]};
    if (div_q) begin
      // Borrow out of the subtract means the divisor did not fit: restore.
      if (diff[WIDTH]) acc_next = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Operand load on accept, then one step per RUN cycle.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= {{WIDTH{1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO pair.
// Owns the IDLE -> RUN -> FIX sequencing, operand sign handling, the
// final sign correction and the HI/LO registers (including mthi/mtlo).
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI_result,
  output logic [WIDTH-1:0] LO_result
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  op_t                op_q;
  logic               neg_res_q;   // product / quotient must be negated
  logic               neg_rem_q;   // remainder must be negated
  logic               dz_q;        // divisor was zero
  logic [WIDTH-1:0]   a_raw_q;     // raw dividend for the divide-by-zero HI value

  op_t                op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               core_load, core_step;
  logic [WIDTH-1:0]   core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_in     = op_t'(op);
  assign in_signed = op_is_signed(op_in);
  assign mag_a     = (in_signed && Read_data_1[WIDTH-1]) ? -Read_data_1 : Read_data_1;
  assign mag_b     = (in_signed && Read_data_2[WIDTH-1]) ? -Read_data_2 : Read_data_2;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (core_load),
    .step    (core_step),
    .is_div  (op_is_div(op_in)),
    .a       (mag_a),
    .b       (mag_b),
    .hi      (core_hi),
    .lo      (core_lo)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          core_load = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        core_step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and iteration counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) cnt_q <= '0;
      else if (state_q == S_RUN)      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture operation, signs and raw dividend when an operation is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
    end else if (state_q == S_IDLE && start) begin
      op_q      <= op_in;
      neg_res_q <= in_signed && (Read_data_1[WIDTH-1] ^ Read_data_2[WIDTH-1]);
      neg_rem_q <= in_signed && Read_data_1[WIDTH-1];
      dz_q      <= (Read_data_2 == '0);
      a_raw_q   <= Read_data_1;
    end
  end

  assign prod_raw = {core_hi, core_lo};
  assign prod_fix = neg_res_q ? -prod_raw : prod_raw;
  assign quot_fix = neg_res_q ? -core_lo  : core_lo;
  assign rem_fix  = neg_rem_q ? -core_hi  : core_hi;

  // HI/LO update: final result in FIX, otherwise idle mthi/mtlo writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      HI_result <= '0;
      LO_result <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (state_q == S_FIX) begin
        done <= 1'b1;
        if (op_is_div(op_q)) begin
          if (dz_q) begin
            HI_result <= a_raw_q;
            LO_result <= WIDTH'(DIV0_QUOT);
            div_zero  <= 1'b1;
          end else begin
            HI_result <= rem_fix;
            LO_result <= quot_fix;
          end
        end else begin
          {HI_result, LO_result} <= prod_fix;
        end
      end else if (state_q == S_IDLE && !start) begin
        if (mthi) HI_result <= wdata;
        if (mtlo) LO_result <= wdata;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: vector table + scoreboard queue,
// plus hand-written sequences for reset, mthi/mtlo and ignored starts.
module tb_hilo_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] Read_data_1 = '0;
  logic [31:0] Read_data_2 = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI_result, LO_result;

  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t scoreboard[$];
  vec_t table_v[$];

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .Read_data_1 (Read_data_1),
    .Read_data_2 (Read_data_2),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .HI_result   (HI_result),
    .LO_result   (LO_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                              input string name);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz; v.name = name;
    return v;
  endfunction

  // Reference model from plain 64-bit / integer arithmetic.
  function automatic vec_t model(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input string name);
    vec_t   v;
    int     ia, ib;
    longint la, lb, p;
    logic [63:0] pu;
    v = mk(o, a, b, 32'h0, 32'h0, 1'b0, name);
    ia = a; ib = b; la = ia; lb = ib;
    case (o)
      MULT: begin
        p = la * lb;
        {v.hi, v.lo} = p;
      end
      MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        {v.hi, v.lo} = pu;
      end
      default: begin
        if (b == 32'h0) begin
          v.hi = a; v.lo = 32'hFFFF_FFFF; v.dz = 1'b1;
        end else if (o == DIV) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.lo = 32'h8000_0000; v.hi = 32'h0;
          end else begin
            v.lo = ia / ib; v.hi = ia % ib;
          end
        end else begin
          v.lo = a / b; v.hi = a % b;
        end
      end
    endcase
    return v;
  endfunction

  // Issue one operation, push its expectation, and compare when done arrives.
  task automatic do_op(input vec_t v, input int extra_start_cyc, input int mthi_cyc,
                       input bit start_mtlo);
    logic [31:0] hi_before, lo_before;
    int   cyc, busy_cnt, done_cyc, extra_dones;
    vec_t e;
    @(negedge clock);
    op = v.op; Read_data_1 = v.a; Read_data_2 = v.b; start = 1'b1;
    hi_before = HI_result; lo_before = LO_result;
    if (start_mtlo) begin mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
    scoreboard.push_back(v);
    @(posedge clock); #1;
    cyc = 1; start = 1'b0; mtlo = 1'b0;
    Read_data_1 = $urandom; Read_data_2 = $urandom;
    if (start_mtlo) check({v.name, " start+mtlo LO"}, LO_result, lo_before);
    busy_cnt = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 100) begin
      if (done) done_cyc = cyc;
      else begin
        if (busy) busy_cnt++;
        if (mthi_cyc > 0 && cyc == mthi_cyc + 1)
          check({v.name, " mthi busy HI"}, HI_result, hi_before);
        if (cyc == extra_start_cyc) begin start = 1'b1; op = MULTU; end
        if (cyc == mthi_cyc) begin mthi = 1'b1; wdata = 32'hA5A5_5A5A; end
        @(posedge clock); #1;
        cyc++; start = 1'b0; mthi = 1'b0;
      end
    end
    check({v.name, " done cycle"}, done_cyc, 34);
    check({v.name, " busy cycles"}, busy_cnt, 33);
    check({v.name, " busy at done"}, busy, 1'b0);
    e = scoreboard.pop_front();
    check({e.name, " HI"}, HI_result, e.hi);
    check({e.name, " LO"}, LO_result, e.lo);
    check({e.name, " div_zero"}, div_zero, e.dz);
    @(posedge clock); #1;
    check({v.name, " done pulse width"}, done, 1'b0);
    if (extra_start_cyc > 0) begin
      extra_dones = 0;
      repeat (50) begin
        @(posedge clock); #1;
        if (done) extra_dones++;
      end
      check({v.name, " extra done pulses"}, extra_dones, 0);
    end
  endtask

  initial begin
    int dones;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset HI", HI_result, 32'h0);
    check("reset LO", LO_result, 32'h0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset div_zero", div_zero, 1'b0);
    @(negedge clock); reset_n = 1'b1;

    // Idle mthi+mtlo together, then mthi alone.
    @(negedge clock); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    @(posedge clock); #1; mthi = 1'b0; mtlo = 1'b0;
    check("mthi+mtlo HI", HI_result, 32'h1234_5678);
    check("mthi+mtlo LO", LO_result, 32'h1234_5678);
    @(negedge clock); mthi = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clock); #1; mthi = 1'b0;
    check("mthi only HI", HI_result, 32'hCAFE_F00D);
    check("mthi only LO", LO_result, 32'h1234_5678);

    // Reset in the middle of a running operation.
    @(negedge clock); op = MULT; Read_data_1 = 32'd5; Read_data_2 = 32'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (9) @(posedge clock);
    #1; reset_n = 1'b0; #1;
    check("midop reset HI", HI_result, 32'h0);
    check("midop reset LO", LO_result, 32'h0);
    check("midop reset busy", busy, 1'b0);
    @(negedge clock); reset_n = 1'b1;
    dones = 0;
    repeat (45) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("midop reset no done", dones, 0);
    check("midop reset busy after", busy, 1'b0);

    // Vector table: literal expectations first, then model-checked randoms.
    table_v.push_back(mk(MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult -3x7"));
    table_v.push_back(mk(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max"));
    table_v.push_back(mk(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, "mult min*min"));
    table_v.push_back(mk(DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2"));
    table_v.push_back(mk(DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 1'b0, "div 100/-7"));
    table_v.push_back(mk(DIVU,  32'd7,         32'd0,        32'd7,        32'hFFFF_FFFF, 1'b1, "divu 7/0"));
    table_v.push_back(mk(DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div -7/0"));
    table_v.push_back(mk(DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,        32'h1999_9999, 1'b0, "divu max/10"));
    for (int i = 0; i < 6; i++)
      table_v.push_back(model(2'($urandom_range(0, 3)), $urandom, $urandom, $sformatf("rand%0d", i)));
    for (int i = 0; i < table_v.size(); i++)
      do_op(table_v[i], 0, 0, 1'b0);

    // Signed overflow with a second start mid-run that must be ignored.
    do_op(mk(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div ovf"), 5, 0, 1'b0);
    // mthi while busy leaves HI alone until the result lands.
    do_op(mk(MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, "mult 3x4 mthi"), 0, 3, 1'b0);
    // mtlo in the same cycle as start is dropped.
    do_op(mk(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu start+mtlo"), 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
